// File: rtl/pipeline_pkg.sv
// Shared definitions for the IF/ID pipeline register: instruction field
// positions, the NOP encoding and the stall FSM state type.
package pipeline_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam int          RS_MSB    = 25;
    localparam int          RS_LSB    = 21;
    localparam int          RT_MSB    = 20;
    localparam int          RT_LSB    = 16;
    localparam logic [4:0]  REG_ZERO  = 5'd0;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } fsm_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the instruction in ID and a load in EX.
// Both source fields are compared regardless of opcode.
module hazard_detect
    import pipeline_pkg::*;
(
    input  logic       valid,
    input  logic       idex_mem_read,
    input  logic [4:0] idex_reg_rt,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    output logic       hazard
);

    // Writes to $zero never produce a value, so they cannot cause a hazard.
    assign hazard = valid && idex_mem_read && (idex_reg_rt != REG_ZERO) &&
                    ((idex_reg_rt == rs) || (idex_reg_rt == rt));

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use stall, redirect flush and
// saturating stall/flush event counters.
module if_id_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] instr_in,
    input  logic [DATA_W-1:0] pc_plus_4_in,
    input  logic              flush,
    input  logic              idex_mem_read,
    input  logic [4:0]        idex_reg_rt,
    output logic [DATA_W-1:0] instr_out,
    output logic [DATA_W-1:0] pc_plus_4_out,
    output logic              valid_out,
    output logic              pc_write,
    output logic              ctrl_zero,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    fsm_state_t state;
    logic       hazard;
    logic       stall_now;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    hazard_detect u_hazard_detect (
        .valid         (valid_out),
        .idex_mem_read (idex_mem_read),
        .idex_reg_rt   (idex_reg_rt),
        .rs            (instr_out[RS_MSB:RS_LSB]),
        .rt            (instr_out[RT_MSB:RT_LSB]),
        .hazard        (hazard)
    );

    // Flush and reset both override a pending hazard.
    assign stall_now = hazard && !flush && !rst;
    assign pc_write  = !stall_now;
    assign ctrl_zero = stall_now;

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_out     <= '0;
            pc_plus_4_out <= '0;
            valid_out     <= 1'b0;
            stall_cnt     <= '0;
            flush_cnt     <= '0;
            state         <= RUN;
        end else if (flush) begin
            instr_out     <= DATA_W'(NOP_INSTR);
            pc_plus_4_out <= pc_plus_4_in;
            valid_out     <= 1'b0;
            flush_cnt     <= sat_inc(flush_cnt);
            state         <= RUN;
        end else if (hazard) begin
            // A repeated hazard while already stalled simply stalls again.
            stall_cnt     <= sat_inc(stall_cnt);
            state         <= STALL;
        end else begin
            instr_out     <= instr_in;
            pc_plus_4_out <= pc_plus_4_in;
            valid_out     <= 1'b1;
            if (state == STALL) begin
                state <= RUN;
            end
        end
    end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed testbench for if_id_stage: reset, capture, load-use stall,
// $zero exemption, flush priority, reset mid-stall and counter saturation.
module tb_if_id_stage;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] instr_in;
    logic [DATA_W-1:0] pc_plus_4_in;
    logic              flush;
    logic              idex_mem_read;
    logic [4:0]        idex_reg_rt;
    logic [DATA_W-1:0] instr_out;
    logic [DATA_W-1:0] pc_plus_4_out;
    logic              valid_out;
    logic              pc_write;
    logic              ctrl_zero;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    if_id_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .instr_in      (instr_in),
        .pc_plus_4_in  (pc_plus_4_in),
        .flush         (flush),
        .idex_mem_read (idex_mem_read),
        .idex_reg_rt   (idex_reg_rt),
        .instr_out     (instr_out),
        .pc_plus_4_out (pc_plus_4_out),
        .valid_out     (valid_out),
        .pc_write      (pc_write),
        .ctrl_zero     (ctrl_zero),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset_and_load(input logic [31:0] instr, input logic [31:0] pc);
        rst = 1'b1; flush = 1'b0; idex_mem_read = 1'b0; idex_reg_rt = 5'd0;
        step();
        rst = 1'b0; instr_in = instr; pc_plus_4_in = pc;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; idex_mem_read = 1'b1; idex_reg_rt = 5'd9;
        instr_in = 32'hDEADBEEF; pc_plus_4_in = 32'h100;
        step(); step();
        n_tests++;
        if (instr_out !== 32'h0 || pc_plus_4_out !== 32'h0 || valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_regs: got instr=%h pc=%h vld=%b, want 0 0 0", instr_out, pc_plus_4_out, valid_out);
        end
        n_tests++;
        if (stall_cnt !== 16'h0 || flush_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_cnts: got stall=%h flush=%h, want 0 0", stall_cnt, flush_cnt);
        end
        n_tests++;
        if (pc_write !== 1'b1 || ctrl_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_comb: got pc_write=%b ctrl_zero=%b, want 1 0", pc_write, ctrl_zero);
        end
    endtask

    task automatic test_normal();
        rst = 1'b0; idex_mem_read = 1'b0; idex_reg_rt = 5'd0;
        instr_in = 32'h012A4020; pc_plus_4_in = 32'h4;
        step();
        n_tests++;
        if (instr_out !== 32'h012A4020 || pc_plus_4_out !== 32'h4 || valid_out !== 1'b1) begin
            n_fail++;
            $display("FAIL normal_capture: got instr=%h pc=%h vld=%b, want 012a4020 4 1", instr_out, pc_plus_4_out, valid_out);
        end
        n_tests++;
        if (pc_write !== 1'b1 || ctrl_zero !== 1'b0 || stall_cnt !== 16'h0 || flush_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL normal_ctrl: got pc_write=%b ctrl_zero=%b stall=%h flush=%h, want 1 0 0 0",
                     pc_write, ctrl_zero, stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_load_use();
        // instr_out = 012A4020 (rs=9, rt=10); load in EX writes $9
        idex_mem_read = 1'b1; idex_reg_rt = 5'd9;
        instr_in = 32'h014B4820; pc_plus_4_in = 32'h8;
        #1;
        n_tests++;
        if (pc_write !== 1'b0 || ctrl_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL load_use_comb: got pc_write=%b ctrl_zero=%b, want 0 1", pc_write, ctrl_zero);
        end
        step();
        n_tests++;
        if (instr_out !== 32'h012A4020 || pc_plus_4_out !== 32'h4 || stall_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL load_use_hold: got instr=%h pc=%h stall=%0d, want 012a4020 4 1", instr_out, pc_plus_4_out, stall_cnt);
        end
        idex_mem_read = 1'b0;
        #1;
        n_tests++;
        if (pc_write !== 1'b1 || ctrl_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL load_use_release: got pc_write=%b ctrl_zero=%b, want 1 0", pc_write, ctrl_zero);
        end
        step();
        n_tests++;
        if (instr_out !== 32'h014B4820 || pc_plus_4_out !== 32'h8 || valid_out !== 1'b1 || stall_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL load_use_resume: got instr=%h pc=%h vld=%b stall=%0d, want 014b4820 8 1 1",
                     instr_out, pc_plus_4_out, valid_out, stall_cnt);
        end
        // rt-field match: 014B4820 has rt=11
        idex_mem_read = 1'b1; idex_reg_rt = 5'd11;
        #1;
        n_tests++;
        if (pc_write !== 1'b0 || ctrl_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL load_use_rt: got pc_write=%b ctrl_zero=%b, want 0 1", pc_write, ctrl_zero);
        end
        idex_mem_read = 1'b0;
        instr_in = 32'h01000008; pc_plus_4_in = 32'hC;
        step();
        n_tests++;
        if (instr_out !== 32'h01000008 || pc_plus_4_out !== 32'hC) begin
            n_fail++;
            $display("FAIL run_after_stall: got instr=%h pc=%h, want 01000008 c", instr_out, pc_plus_4_out);
        end
    endtask

    task automatic test_zero_reg();
        // instr_out = 01000008 (rs=8, rt=0); load targets $zero
        idex_mem_read = 1'b1; idex_reg_rt = 5'd0;
        instr_in = 32'h00000020; pc_plus_4_in = 32'h10;
        #1;
        n_tests++;
        if (pc_write !== 1'b1 || ctrl_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_reg_comb: got pc_write=%b ctrl_zero=%b, want 1 0", pc_write, ctrl_zero);
        end
        step();
        n_tests++;
        if (instr_out !== 32'h00000020 || pc_plus_4_out !== 32'h10 || stall_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL zero_reg_capture: got instr=%h pc=%h stall=%0d, want 00000020 10 1",
                     instr_out, pc_plus_4_out, stall_cnt);
        end
        idex_mem_read = 1'b0;
    endtask

    task automatic test_flush_beats_hazard();
        do_reset_and_load(32'h012A4020, 32'h4);
        idex_mem_read = 1'b1; idex_reg_rt = 5'd9; flush = 1'b1;
        instr_in = 32'h11111111; pc_plus_4_in = 32'h40;
        #1;
        n_tests++;
        if (pc_write !== 1'b1 || ctrl_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_comb: got pc_write=%b ctrl_zero=%b, want 1 0", pc_write, ctrl_zero);
        end
        step();
        n_tests++;
        if (instr_out !== 32'h0 || valid_out !== 1'b0 || pc_plus_4_out !== 32'h40) begin
            n_fail++;
            $display("FAIL flush_regs: got instr=%h vld=%b pc=%h, want 0 0 40", instr_out, valid_out, pc_plus_4_out);
        end
        n_tests++;
        if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL flush_cnts: got flush=%0d stall=%0d, want 1 0", flush_cnt, stall_cnt);
        end
        flush = 1'b0;
        #1;
        n_tests++;
        if (pc_write !== 1'b1) begin
            n_fail++;
            $display("FAIL post_flush_nop: got pc_write=%b, want 1", pc_write);
        end
        idex_mem_read = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        do_reset_and_load(32'h012A4020, 32'h4);
        idex_mem_read = 1'b1; idex_reg_rt = 5'd9;
        step();
        n_tests++;
        if (stall_cnt !== 16'd1 || pc_write !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_stall_enter: got stall=%0d pc_write=%b, want 1 0", stall_cnt, pc_write);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (pc_write !== 1'b1 || ctrl_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_stall_rst_comb: got pc_write=%b ctrl_zero=%b, want 1 0", pc_write, ctrl_zero);
        end
        step();
        n_tests++;
        if (instr_out !== 32'h0 || pc_plus_4_out !== 32'h0 || valid_out !== 1'b0 ||
            stall_cnt !== 16'h0 || flush_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL mid_stall_rst: got instr=%h pc=%h vld=%b stall=%h flush=%h, want all 0",
                     instr_out, pc_plus_4_out, valid_out, stall_cnt, flush_cnt);
        end
        rst = 1'b0; idex_mem_read = 1'b0;
        instr_in = 32'h22222222; pc_plus_4_in = 32'h80;
        step();
        n_tests++;
        if (instr_out !== 32'h22222222 || valid_out !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_stall_resume: got instr=%h vld=%b, want 22222222 1", instr_out, valid_out);
        end
    endtask

    task automatic test_saturation();
        do_reset_and_load(32'h012A4020, 32'h4);
        idex_mem_read = 1'b1; idex_reg_rt = 5'd10;
        repeat ((1 << CNT_W) + 3) @(posedge clk);
        #1;
        n_tests++;
        if (stall_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL stall_saturate: got stall=%h, want ffff", stall_cnt);
        end
        n_tests++;
        if (instr_out !== 32'h012A4020 || pc_write !== 1'b0) begin
            n_fail++;
            $display("FAIL saturate_hold: got instr=%h pc_write=%b, want 012a4020 0", instr_out, pc_write);
        end
        idex_mem_read = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; idex_mem_read = 1'b0; idex_reg_rt = 5'd0;
        instr_in = '0; pc_plus_4_in = '0;
        test_reset();
        test_normal();
        test_load_use();
        test_zero_reg();
        test_flush_beats_hazard();
        test_reset_mid_stall();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- IF/ID pipeline register with integrated load-use hazard detection, feeding the ID stage and, through decode, the ID/EX register.
- Holds the fetched instruction and PC+4.
- Stalls fetch for one cycle on a load-use hazard and forces a bubble into ID/EX.
- Flushes to a NOP on taken branch or jump redirect.
- Keeps saturating stall and flush event counters for SAD-kernel performance measurement.

Parameters:
- DATA_W, 32, width of instruction and PC+4 paths.
- CNT_W, 16, width of the saturating stall and flush counters.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- instr_in  input  DATA_W  instruction from instruction memory
- pc_plus_4_in  input  DATA_W  PC+4 from fetch
- flush  input  1  taken branch or jump redirect, resolved downstream
- idex_mem_read  input  1  MemRead held in ID/EX
- idex_reg_rt  input  5  destination rt held in ID/EX
- instr_out  output  DATA_W  registered instruction to decode
- pc_plus_4_out  output  DATA_W  registered PC+4
- valid_out  output  1  instr_out is a real instruction, not a bubble or NOP
- pc_write  output  1  0 = PC must hold this cycle
- ctrl_zero  output  1  1 = decode must drive all ID/EX control inputs to 0
- stall_cnt  output  CNT_W  count of stall cycles
- flush_cnt  output  CNT_W  count of flush cycles

Behaviour:
- Reset (rst=1 at posedge):
  - instr_out=0, pc_plus_4_out=0, valid_out=0.
  - stall_cnt=0, flush_cnt=0.
  - FSM returns to RUN.
- Reset wins over every other input, including mid-stall.
- The combinational outputs pc_write and ctrl_zero also read 1 and 0 respectively while rst=1.
- Hazard (combinational) is asserted when all of the following hold:
  - valid_out=1
  - idex_mem_read=1
  - idex_reg_rt != 0
  - idex_reg_rt == instr_out[25:21] or idex_reg_rt == instr_out[20:16]
- Both fields are compared regardless of opcode. This is conservative and accepted.
- FSM states: RUN and STALL.
  - RUN, hazard=1 and flush=0: go to STALL. pc_write=0, ctrl_zero=1, registers hold, stall_cnt+1.
  - RUN, no hazard and no flush: capture instr_in and pc_plus_4_in, valid_out<=1. pc_write=1, ctrl_zero=0.
  - STALL: hazard must have cleared because the bubble reached ID/EX. Behave exactly as RUN for this cycle (capture or flush) and return to RUN.
  - STALL with hazard still 1 (illegal back-to-back load-use on the same instruction): stall again and stay in STALL. The counter increments again.
- Flush:
  - At posedge with rst=0: instr_out<=0 (NOP), pc_plus_4_out<=pc_plus_4_in, valid_out<=0, flush_cnt+1, next state RUN.
  - Flush has priority over hazard. When both are present, pc_write=1, ctrl_zero=0, and stall_cnt is not incremented.
- Latency: 1 cycle, instr_in to instr_out, when there is no stall.
- Counters saturate at all-ones and never wrap.
- pc_write and ctrl_zero are purely combinational from the current state and inputs. They are not registered.

Decomposition:
- Shared package (pipeline_pkg), containing:
  - NOP_INSTR = 32'h0
  - RS_MSB/RS_LSB = 25/21
  - RT_MSB/RT_LSB = 20/16
  - REG_ZERO = 5'd0
  - FSM state encoding RUN=1'b0, STALL=1'b1
- One natural sub-module: hazard_detect. It is purely combinational: inputs valid, idex_mem_read, idex_reg_rt, rs, rt; output hazard.

Test Plan:
- Reset then normal flow: rst for 2 cycles, then feed instr_in=32'h012A4020 and pc_plus_4_in=32'h4. Next posedge: instr_out=32'h012A4020, pc_plus_4_out=4, valid_out=1, pc_write=1; counters 0.
- Load-use stall: instr_out rs=9; set idex_mem_read=1, idex_reg_rt=9. Required: pc_write=0, ctrl_zero=1, instr_out held 1 cycle, stall_cnt=1. Then drop idex_mem_read. Required: next instruction captured and FSM back in RUN.
- $zero no-hazard: idex_mem_read=1, idex_reg_rt=0, instr_out rt=0. Required: pc_write=1, ctrl_zero=0, no stall.
- Flush beats hazard: hazard conditions true and flush=1 in the same cycle. Required: instr_out=0, valid_out=0, flush_cnt=1, stall_cnt=0, pc_write=1.
- Reset mid-stall: enter STALL, assert rst. Next posedge: all outputs zero, state RUN, counters 0.
- Saturation: force 2^CNT_W+3 stall cycles. Required: stall_cnt=16'hFFFF, with no wrap.
